// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Drain stage for an 8-bit byte FIFO. The FIFO has a zero-latency read port,
// and this block pops a byte from it whenever the FIFO is non-empty. Bytes are
// packed little-endian into BYTES-wide words: the first byte popped goes into
// bits [7:0]. Each finished word is offered on a valid/ready handshake. A
// flush request emits the current partial word together with its byte count.
//
// Parameters:
//   BYTES  : bytes per output word, 2..8 (default 4)
//   CNT_W  : width of the byte-count output, $clog2(BYTES)+1
//
// Ports:
//   clk                 : clock, rising edge
//   rst                 : synchronous active-high reset
//   in_fifo_is_empty    : FIFO empty flag
//   in_fifo_read_data   : FIFO head byte, valid in the same cycle as the pop
//   out_fifo_read_ctrl  : FIFO pop strobe (combinational)
//   in_flush            : emit the current partial word
//   in_word_ready       : consumer accepts the presented word
//   out_word_valid      : word available
//   out_word_data       : packed word; zero while not valid
//   out_word_byte_count : number of valid bytes in the word, 1..BYTES
//   out_word_parity     : per-lane even parity; exists only when
//                         FIFO_WORD_PACKER_PARITY_EN is defined
//
// Optional feature macro: FIFO_WORD_PACKER_PARITY_EN
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter  int BYTES = 4,
    localparam int CNT_W = $clog2(BYTES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_fifo_is_empty,
    input  logic [7:0]           in_fifo_read_data,
    output logic                 out_fifo_read_ctrl,
    input  logic                 in_flush,
    input  logic                 in_word_ready,
    output logic                 out_word_valid,
    output logic [8*BYTES-1:0]   out_word_data,
    output logic [CNT_W-1:0]     out_word_byte_count
`ifdef FIFO_WORD_PACKER_PARITY_EN
    ,
    output logic [BYTES-1:0]     out_word_parity
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q,   idx_d;
    logic [8*BYTES-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               pop;

    // Pop only while filling and the FIFO has data. The pop is also held
    // low during reset, so the FIFO cannot lose a byte that is about to be
    // discarded.
    assign pop                = (state_q == FILL) && !in_fifo_is_empty && !rst;
    assign out_fifo_read_ctrl = pop;

    // NOTE: every variable written in an always_comb block is first given a
    // default value (here it holds its state). If some path through the block
    // left a variable unassigned, synthesis would infer a latch for it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            FILL: begin
                if (pop) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (idx_q == CNT_W'(i)) begin
                            acc_d[i*8 +: 8] = in_fifo_read_data;
                        end
                    end
                    idx_d = idx_q + CNT_W'(1);
                end

                // A word is complete when the pop fills the last lane. A flush
                // also completes the word, but only if the word holds at least
                // one byte; a byte popped in the same cycle counts.
                if (pop && (idx_q == CNT_W'(BYTES - 1))) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(BYTES);
                end else if (in_flush && ((idx_q != '0) || pop)) begin
                    state_d = HOLD;
                    cnt_d   = idx_q + CNT_W'(pop);
                end
            end

            HOLD: begin
                if (in_word_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: the state registers are updated with non-blocking assignments.
    // Each register then takes the value computed before the clock edge,
    // whatever order the assignments run in.
    // The accumulator is reset as well, even though it is datapath. Lanes
    // that are never written must read back as 0x00 in a partial word, so the
    // accumulator has to start from a known zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_word_valid      = (state_q == HOLD);
    assign out_word_data       = out_word_valid ? acc_q : '0;
    assign out_word_byte_count = cnt_q;

`ifdef FIFO_WORD_PACKER_PARITY_EN
    logic [BYTES-1:0] parity_q, parity_d;

    // Parity is taken from the next accumulator value at the moment the word
    // completes, so it becomes valid together with the word. Lanes that were
    // not written are zero, which gives them a parity bit of 0.
    always_comb begin
        parity_d = parity_q;
        if ((state_q == FILL) && (state_d == HOLD)) begin
            for (int i = 0; i < BYTES; i++) begin
                parity_d[i] = ^acc_d[i*8 +: 8];
            end
        end else if ((state_q == HOLD) && in_word_ready) begin
            parity_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_word_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Self-checking bench for fifo_word_packer with BYTES = 4. Each row of the
// vector table sets the inputs for one clock cycle. The registered outputs
// are checked against hand-computed values before the edge; the pop strobe,
// which is combinational, is checked in the same cycle. Hand-written
// sequences then cover steady-state throughput and, when the macro is
// defined, the parity lanes.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

    localparam int BYTES = 4;
    localparam int CNT_W = $clog2(BYTES) + 1;

    logic               clk;
    logic               rst;
    logic               in_fifo_is_empty;
    logic [7:0]         in_fifo_read_data;
    logic               out_fifo_read_ctrl;
    logic               in_flush;
    logic               in_word_ready;
    logic               out_word_valid;
    logic [8*BYTES-1:0] out_word_data;
    logic [CNT_W-1:0]   out_word_byte_count;
`ifdef FIFO_WORD_PACKER_PARITY_EN
    logic [BYTES-1:0]   out_word_parity;
`endif

    fifo_word_packer #(.BYTES(BYTES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_fifo_is_empty    (in_fifo_is_empty),
        .in_fifo_read_data   (in_fifo_read_data),
        .out_fifo_read_ctrl  (out_fifo_read_ctrl),
        .in_flush            (in_flush),
        .in_word_ready       (in_word_ready),
        .out_word_valid      (out_word_valid),
        .out_word_data       (out_word_data),
        .out_word_byte_count (out_word_byte_count)
`ifdef FIFO_WORD_PACKER_PARITY_EN
        ,
        .out_word_parity     (out_word_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        empty;
        logic [7:0]  rdata;
        logic        flush;
        logic        ready;
        logic        exp_rd;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] d,
                       input logic f, input logic rdy, input logic x_rd,
                       input logic x_v, input logic [31:0] x_d,
                       input logic [2:0] x_c);
        vec_t v;
        v.rst = r; v.empty = e; v.rdata = d; v.flush = f; v.ready = rdy;
        v.exp_rd = x_rd; v.exp_valid = x_v; v.exp_data = x_d; v.exp_cnt = x_c;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] d,
                         input logic f, input logic rdy);
        rst               = r;
        in_fifo_is_empty  = e;
        in_fifo_read_data = d;
        in_flush          = f;
        in_word_ready     = rdy;
    endtask

    // Watchdog so that the run always ends, even if the design stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int vcount;
        int pcount;
        bit seen;

        //   rst e  data   fl rdy | rd v  data          cnt
        // Full word: 0x11..0x44, consumer ready.
        add(1, 0, 8'h11, 0, 0,   0, 0, 32'h0,        3'd0);
        add(0, 0, 8'h11, 0, 1,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h22, 0, 1,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h33, 0, 1,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h44, 0, 1,   1, 0, 32'h0,        3'd0);
        add(0, 1, 8'h00, 0, 1,   0, 1, 32'h44332211, 3'd4);
        add(0, 1, 8'h00, 0, 1,   0, 0, 32'h0,        3'd0);
        // Backpressure: ready low for 5 HOLD cycles while the FIFO is non-empty.
        add(0, 0, 8'h11, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h22, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h33, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h44, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h55, 0, 0,   0, 1, 32'h44332211, 3'd4);
        add(0, 0, 8'h55, 0, 0,   0, 1, 32'h44332211, 3'd4);
        add(0, 0, 8'h55, 0, 0,   0, 1, 32'h44332211, 3'd4);
        add(0, 0, 8'h55, 0, 0,   0, 1, 32'h44332211, 3'd4);
        add(0, 0, 8'h55, 0, 0,   0, 1, 32'h44332211, 3'd4);
        add(0, 0, 8'h55, 0, 1,   0, 1, 32'h44332211, 3'd4);
        // Ready without valid, and a flush with idx = 0, have no effect.
        add(0, 1, 8'h00, 0, 1,   0, 0, 32'h0,        3'd0);
        add(0, 1, 8'h00, 1, 1,   0, 0, 32'h0,        3'd0);
        add(0, 1, 8'h00, 0, 0,   0, 0, 32'h0,        3'd0);
        // Flush partial: 0xA1, 0xB2, then flush on an empty FIFO.
        add(0, 0, 8'hA1, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'hB2, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 1, 8'h00, 1, 0,   0, 0, 32'h0,        3'd0);
        add(0, 0, 8'hC3, 1, 0,   0, 1, 32'h0000B2A1, 3'd2);
        add(0, 1, 8'h00, 0, 1,   0, 1, 32'h0000B2A1, 3'd2);
        add(0, 1, 8'h00, 0, 0,   0, 0, 32'h0,        3'd0);
        // Flush in the same cycle as the third pop.
        add(0, 0, 8'hA1, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'hB2, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'hC3, 1, 0,   1, 0, 32'h0,        3'd0);
        add(0, 1, 8'h00, 0, 1,   0, 1, 32'h00C3B2A1, 3'd3);
        add(0, 1, 8'h00, 0, 0,   0, 0, 32'h0,        3'd0);
        // Reset after 3 pops, then a new word, then reset in HOLD.
        add(0, 0, 8'h01, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h02, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h03, 0, 0,   1, 0, 32'h0,        3'd0);
        add(1, 0, 8'h04, 0, 0,   0, 0, 32'h0,        3'd0);
        add(0, 0, 8'h05, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h06, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h07, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 0, 8'h08, 0, 0,   1, 0, 32'h0,        3'd0);
        add(0, 1, 8'h00, 0, 0,   0, 1, 32'h08070605, 3'd4);
        add(1, 1, 8'h00, 0, 0,   0, 1, 32'h08070605, 3'd4);
        add(0, 1, 8'h00, 0, 0,   0, 0, 32'h0,        3'd0);

        // Reset the design before the first table row.
        drive(1, 1, 8'h00, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].empty, vecs[i].rdata, vecs[i].flush,
                  vecs[i].ready);
            #1;
            check($sformatf("row%0d_rd", i),    64'(out_fifo_read_ctrl),  64'(vecs[i].exp_rd));
            check($sformatf("row%0d_valid", i), 64'(out_word_valid),      64'(vecs[i].exp_valid));
            check($sformatf("row%0d_data", i),  64'(out_word_data),       64'(vecs[i].exp_data));
            check($sformatf("row%0d_cnt", i),   64'(out_word_byte_count), 64'(vecs[i].exp_cnt));
            @(posedge clk);
            #1;
        end

        // Steady state with the consumer always ready: one word per 5 cycles.
        vcount = 0;
        pcount = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 8'(c + 1), 0, 1);
            #1;
            if (out_word_valid)     vcount++;
            if (out_fifo_read_ctrl) pcount++;
            if (c == 4) check("stream_word0", 64'(out_word_data), 64'h04030201);
            if (c == 9) check("stream_word1", 64'(out_word_data), 64'h09080706);
            @(posedge clk);
            #1;
        end
        check("stream_valid_count", 64'(vcount), 64'd2);
        check("stream_pop_count",   64'(pcount), 64'd8);
        drive(0, 1, 8'h00, 0, 0);
        #1;
        check("stream_idle_valid", 64'(out_word_valid), 64'd0);

`ifdef FIFO_WORD_PACKER_PARITY_EN
        // Parity lanes: 0x01 -> 1, 0x03 -> 0, 0x07 -> 1, 0x00 -> 0.
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) begin
            drive(0, 0, (b == 0) ? 8'h01 : (b == 1) ? 8'h03 : (b == 2) ? 8'h07 : 8'h00, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 1, 8'h00, 0, 0);
        seen = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            #1;
            if (out_word_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("parity_word_valid", 64'(seen), 64'd1);
        check("parity_data",  64'(out_word_data),   64'h00070301);
        check("parity_bits",  64'(out_word_parity), 64'b0101);
        drive(0, 1, 8'h00, 0, 1);
        @(posedge clk);
        #1;
        drive(0, 1, 8'h00, 0, 0);
        #1;
        check("parity_cleared", 64'(out_word_parity), 64'd0);
`else
        seen = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream drain stage for the 8-bit byte FIFO. It pops bytes from the FIFO's zero-latency read port whenever the FIFO is non-empty and packs them little-endian into `BYTES`-wide words. Each completed word is presented on a valid/ready output handshake. A flush input emits a partial word with its byte count, so the tail of a transfer never stalls in the packer.

## Interface
- `BYTES`, default 4: bytes per output word; legal range 2..8.
- `CNT_W`, localparam `$clog2(BYTES)+1`: width of the byte-count output.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_fifo_is_empty`, input, 1: FIFO empty flag.
- `in_fifo_read_data`, input, 8: FIFO head byte; valid in the same cycle as the read strobe.
- `out_fifo_read_ctrl`, output, 1: FIFO pop strobe; combinational.
- `in_flush`, input, 1: request to emit the current partial word.
- `in_word_ready`, input, 1: consumer accepts the word.
- `out_word_valid`, output, 1: word available.
- `out_word_data`, output, 8*BYTES: packed word; byte 0 in bits [7:0].
- `out_word_byte_count`, output, CNT_W: valid bytes in the word, 1..BYTES.

## Operation
- State machine with two states, FILL and HOLD. Byte index `idx` runs 0..BYTES-1. Accumulator register is 8*BYTES wide.
- Reset:
  - state = FILL, idx = 0, accumulator = 0.
  - `out_word_valid` = 0, `out_word_data` = 0, `out_word_byte_count` = 0.
  - `out_fifo_read_ctrl` is forced to 0 while `rst` is high.
- FILL:
  - `out_fifo_read_ctrl` = !`in_fifo_is_empty`.
  - On a pop, `in_fifo_read_data` is written into lane `idx`, and idx increments.
- FILL to HOLD happens when either:
  - a pop fills lane BYTES-1: count = BYTES; or
  - `in_flush` = 1 and (idx > 0 or a pop occurs this cycle): count = idx + (pop ? 1 : 0).
  - The byte popped in a flush cycle is included in the word.
- Flush in FILL with idx = 0 and no pop is ignored. No empty word is ever emitted.
- HOLD:
  - `out_word_valid` = 1; `out_word_data` and `out_word_byte_count` are held stable.
  - `out_fifo_read_ctrl` = 0.
  - `in_flush` is ignored.
- HOLD to FILL on `in_word_ready` = 1: idx, accumulator and count clear to 0, and `out_word_valid` drops the next cycle.
- Lanes not written in a partial word read as 0x00.
- `out_word_data` is 0 whenever `out_word_valid` = 0.
- No pop is ever issued when `in_fifo_is_empty` = 1. The packer relies on this to never underflow the FIFO.

## Timing
- Pop to lane write: same edge. The byte is sampled on the edge at which `out_fifo_read_ctrl` is high.
- `out_word_valid` rises 1 cycle after the completing pop or flush.
- Accept to next pop: the first pop can occur in the cycle after the accepting edge.
- Steady-state throughput with the consumer always ready: one word per BYTES+1 cycles.
- Reset asserted mid-word or in HOLD discards the partial or held word. Outputs take reset values on the next edge.
- `in_word_ready` while `out_word_valid` = 0 has no effect.

## Configuration
- `FIFO_WORD_PACKER_PARITY_EN`
  - Defined: adds output `out_word_parity` [BYTES-1:0], one even-parity bit per lane (XOR of that lane's 8 bits). It is registered alongside `out_word_data`, 0 for unused lanes, and 0 in reset.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Full word:** BYTES=4; FIFO holds 0x11,0x22,0x33,0x44; ready held high.
  - 4 consecutive pops, then valid = 1 for one cycle.
  - data = 0x44332211, count = 4, then idle.
- **Backpressure:** same stimulus with ready low for 5 cycles.
  - valid stays 1; data and count are stable.
  - `out_fifo_read_ctrl` stays 0 while the FIFO is non-empty.
  - Word completes the cycle after ready rises.
- **Flush partial:** 2 bytes 0xA1,0xB2 popped, FIFO empty, flush pulsed.
  - data = 0x0000B2A1, count = 2.
  - A flush pulse with idx = 0 produces no valid.
- **Flush with same-cycle pop:** flush coincides with the third pop, byte 0xC3.
  - data = 0x00C3B2A1, count = 3.
- **Reset mid-word:** rst asserted after 3 pops.
  - All outputs are 0 the next cycle.
  - After release, 4 new bytes produce a word containing only the new bytes.
- **Parity (macro defined):** bytes 0x01,0x03,0x07,0x00.
  - `out_word_parity` = 4'b0101 (lane0 = 1, lane1 = 0, lane2 = 1, lane3 = 0).
